spi_fetch_queue: RTL and testbench

Instruction prefetch queue that sits between the SPI byte reader and the CPU sequencer/ExecutionUnit. It issues byte reads ahead of execution, buffers up to DEPTH bytes, and hands 4-bit opcodes to the consumer one at a time (low nibble first) over a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new address, which is the hook for jumps and branches.

---
 rtl/spi_fetch_queue_if.sv | 31 +++
 rtl/spi_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_spi_fetch_queue.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fetch_queue_if.sv
// Handshake bundle for spi_fetch_queue: SPI byte-reader request/response, redirect and opcode stream.
// slave = the queue itself, master = reader/sequencer side.
interface spi_fetch_queue_if #(
  parameter int PC_W   = 12,
  parameter int ADDR_W = 16,
  parameter int LVL_W  = 3
);
  logic              redirect;
  logic [PC_W-1:0]   redirect_addr;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic              rd_done;
  logic [7:0]        rd_data;
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        opcode;
  logic [PC_W-1:0]   op_addr;
  logic              op_hi;
  logic [LVL_W-1:0]  level;

  modport slave (
    input  redirect, redirect_addr, rd_busy, rd_done, rd_data, op_ready,
    output rd_start, rd_addr, op_valid, opcode, op_addr, op_hi, level
  );

  modport master (
    output redirect, redirect_addr, rd_busy, rd_done, rd_data, op_ready,
    input  rd_start, rd_addr, op_valid, opcode, op_addr, op_hi, level
  );
endinterface

// File: rtl/spi_fetch_queue.sv
// Instruction prefetch queue: issues SPI byte reads ahead of execution, buffers DEPTH bytes
// and presents them as 4-bit opcodes (low nibble first); redirect flushes and restarts fetch.
module spi_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 12,
  parameter int ADDR_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  spi_fetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_op_hi;
  logic [PC_W-1:0]   r_fetch_pc;
  logic [PC_W-1:0]   r_head_pc;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_issue;
  logic              w_not_full;
  logic              w_push;
  logic              w_take;
  logic              w_pop;
  logic              w_op_valid;
  logic [7:0]        w_head;
  logic [PC_W-1:0]   w_fetch_pc_nxt;

  assign w_not_full = (r_level < LVL_W'(DEPTH));
  assign w_op_valid = (r_level != '0);
  assign w_head     = r_mem[r_rptr];
  assign w_push     = (r_state == S_WAIT) && bus.rd_done && !bus.redirect;
  assign w_take     = w_op_valid && bus.op_ready && !bus.redirect;
  assign w_pop      = w_take && r_op_hi;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.redirect && w_not_full && !bus.rd_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect) begin
          w_state_nxt = bus.rd_done ? S_IDLE : S_DRAIN;
        end else if (bus.rd_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.rd_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (bus.redirect) begin
      w_fetch_pc_nxt = bus.redirect_addr;
    end else if (w_push) begin
      w_fetch_pc_nxt = r_fetch_pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_op_hi    <= 1'b0;
      r_fetch_pc <= '0;
      r_head_pc  <= '0;
      r_rd_addr  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      // rd_addr shadows fetch_pc only while idle, so it holds steady across an in-flight read
      if (w_state_nxt == S_IDLE) begin
        r_rd_addr <= ADDR_W'(w_fetch_pc_nxt);
      end
      if (bus.redirect) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_level   <= '0;
        r_op_hi   <= 1'b0;
        r_head_pc <= bus.redirect_addr;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
        if (w_take) begin
          r_op_hi <= !r_op_hi;
        end
        if (w_pop) begin
          r_rptr    <= r_rptr + PTR_W'(1);
          r_head_pc <= r_head_pc + PC_W'(1);
        end
        unique case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_W'(1);
          2'b01:   r_level <= r_level - LVL_W'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= bus.rd_data;
    end
  end

  assign bus.rd_start = w_issue && !reset;
  assign bus.rd_addr  = r_rd_addr;
  assign bus.op_valid = w_op_valid;
  assign bus.opcode   = !w_op_valid ? 4'h0 : (r_op_hi ? w_head[7:4] : w_head[3:0]);
  assign bus.op_addr  = r_head_pc;
  assign bus.op_hi    = r_op_hi;
  assign bus.level    = r_level;

endmodule

// File: tb/tb_spi_fetch_queue.sv
// Scoreboard bench for spi_fetch_queue: a behavioural SPI reader answers reads from a fixed
// byte table, expected opcodes/addresses are queued by the stimulus and popped by monitors.
module tb_spi_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int PC_W   = 12;
  localparam int ADDR_W = 16;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]      op;
    logic [PC_W-1:0] addr;
    logic            hi;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_fetch_queue_if #(.PC_W(PC_W), .ADDR_W(ADDR_W), .LVL_W(LVL_W)) bus ();

  spi_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] exp_rd[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                rd_cnt  = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endfunction

  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    case (a)
      16'h0000: mem_byte = 8'h21;
      16'h0001: mem_byte = 8'h43;
      16'h0002: mem_byte = 8'h65;
      16'h0003: mem_byte = 8'h87;
      16'h0004: mem_byte = 8'hA9;
      16'h0100: mem_byte = 8'h5C;
      16'h0FFF: mem_byte = 8'hDE;
      default:  mem_byte = a[7:0] ^ 8'h3C;
    endcase
  endfunction

  // SPI reader: busy one cycle after the request is seen, data returned on the third cycle
  initial begin
    logic              pending;
    int unsigned       cnt;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] e;
    pending = 1'b0;
    cnt = 0;
    a = '0;
    bus.rd_busy = 1'b0;
    bus.rd_done = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      bus.rd_done = 1'b0;
      if (pending) begin
        cnt++;
        if (cnt == 1) begin
          bus.rd_busy = 1'b1;
        end else if (cnt == 3) begin
          bus.rd_busy = 1'b0;
          bus.rd_done = 1'b1;
          bus.rd_data = mem_byte(a);
          pending = 1'b0;
        end
      end
      #2;
      if (reset) begin
        pending = 1'b0;
        bus.rd_busy = 1'b0;
        bus.rd_done = 1'b0;
      end else if (bus.rd_start) begin
        chk("rd_start_while_busy", 32'(bus.rd_busy), 32'h0);
        chk("rd_start_overlap", 32'(pending), 32'h0);
        rd_cnt++;
        a = bus.rd_addr;
        if (exp_rd.size() != 0) begin
          e = exp_rd.pop_front();
          chk("rd_addr", 32'(a), 32'(e));
        end
        pending = 1'b1;
        cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.op_valid && bus.op_ready && !bus.redirect && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("opcode", 32'(bus.opcode), 32'(e.op));
        chk("op_addr", 32'(bus.op_addr), 32'(e.addr));
        chk("op_hi", 32'(bus.op_hi), 32'(e.hi));
      end
    end
  end

  task automatic push_exp(input logic [3:0] op, input logic [PC_W-1:0] addr, input logic hi);
    exp_t e;
    e.op = op;
    e.addr = addr;
    e.hi = hi;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.op_ready = 1'b0;
    bus.redirect = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_rd.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_start"}, 32'(bus.rd_start), 32'h0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'h0);
    chk({tag, "_op_valid"}, 32'(bus.op_valid), 32'h0);
    chk({tag, "_opcode"}, 32'(bus.opcode), 32'h0);
    chk({tag, "_op_addr"}, 32'(bus.op_addr), 32'h0);
    chk({tag, "_op_hi"}, 32'(bus.op_hi), 32'h0);
    chk({tag, "_level"}, 32'(bus.level), 32'h0);
  endtask

  task automatic wait_drain(input string name, input int unsigned lim);
    int unsigned i;
    i = 0;
    while (exp_q.size() != 0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic wait_rd_cnt(input string name, input int n);
    for (int unsigned i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_cnt >= n) break;
    end
    chk(name, 32'(rd_cnt), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect = 1'b0;
    bus.redirect_addr = '0;
    bus.op_ready = 1'b0;

    // 1: in-order nibble stream from bytes 0x21,0x43,0x65
    do_reset();
    #2;
    check_reset_vals("t1_reset");
    push_exp(4'h1, 12'h000, 1'b0);
    push_exp(4'h2, 12'h000, 1'b1);
    push_exp(4'h3, 12'h001, 1'b0);
    push_exp(4'h4, 12'h001, 1'b1);
    push_exp(4'h5, 12'h002, 1'b0);
    push_exp(4'h6, 12'h002, 1'b1);
    exp_rd.push_back(16'h0000);
    exp_rd.push_back(16'h0001);
    exp_rd.push_back(16'h0002);
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    bus.op_ready = 1'b1;
    wait_drain("t1_drain", 200);
    bus.op_ready = 1'b0;

    // 2: fill to DEPTH with consumer stalled, then free one entry
    do_reset();
    for (int unsigned i = 0; i < 4; i++) exp_rd.push_back(ADDR_W'(i));
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    repeat (40) @(negedge clk);
    #2;
    chk("t2_rd_cnt_full", 32'(rd_cnt), 32'd4);
    chk("t2_level_full", 32'(bus.level), 32'd4);
    chk("t2_op_valid", 32'(bus.op_valid), 32'h1);
    chk("t2_head_opcode", 32'(bus.opcode), 32'h1);
    chk("t2_head_addr", 32'(bus.op_addr), 32'h0);
    push_exp(4'h1, 12'h000, 1'b0);
    push_exp(4'h2, 12'h000, 1'b1);
    exp_rd.push_back(16'h0004);
    @(negedge clk);
    bus.op_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.op_ready = 1'b0;
    #2;
    chk("t2_level_after_pop", 32'(bus.level), 32'd3);
    chk("t2_handshakes", 32'(exp_q.size()), 32'h0);
    repeat (10) @(negedge clk);
    #2;
    chk("t2_rd_cnt_refill", 32'(rd_cnt), 32'd5);
    chk("t2_level_refill", 32'(bus.level), 32'd4);
    chk("t2_opcode_refill", 32'(bus.opcode), 32'h3);
    chk("t2_op_addr_refill", 32'(bus.op_addr), 32'h1);
    chk("t2_rd_addrs", 32'(exp_rd.size()), 32'h0);

    // 3: redirect while a read is in flight with one byte queued
    do_reset();
    exp_rd.push_back(16'h0000);
    exp_rd.push_back(16'h0001);
    exp_rd.push_back(16'h0100);
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    wait_rd_cnt("t3_second_read", 2);
    bus.redirect = 1'b1;
    bus.redirect_addr = 12'h100;
    @(negedge clk);
    bus.redirect = 1'b0;
    #2;
    chk("t3_level_flush", 32'(bus.level), 32'h0);
    chk("t3_op_valid_flush", 32'(bus.op_valid), 32'h0);
    chk("t3_op_addr_flush", 32'(bus.op_addr), 32'h100);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("t3_drain_discard", 32'(bus.level), 32'h0);
    push_exp(4'hC, 12'h100, 1'b0);
    push_exp(4'h5, 12'h100, 1'b1);
    @(negedge clk);
    bus.op_ready = 1'b1;
    wait_drain("t3_drain", 100);
    bus.op_ready = 1'b0;
    chk("t3_rd_addrs", 32'(exp_rd.size()), 32'h0);

    // 4: fetch address wraps from 0xFFF to 0x000
    do_reset();
    exp_rd.push_back(16'h0FFF);
    exp_rd.push_back(16'h0000);
    push_exp(4'hE, 12'hFFF, 1'b0);
    push_exp(4'hD, 12'hFFF, 1'b1);
    push_exp(4'h1, 12'h000, 1'b0);
    push_exp(4'h2, 12'h000, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    bus.redirect = 1'b1;
    bus.redirect_addr = 12'hFFF;
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.op_ready = 1'b1;
    wait_drain("t4_drain", 200);
    bus.op_ready = 1'b0;
    chk("t4_rd_addrs", 32'(exp_rd.size()), 32'h0);

    // 5: pop of the only byte coincides with the next byte's return
    do_reset();
    push_exp(4'h1, 12'h000, 1'b0);
    push_exp(4'h2, 12'h000, 1'b1);
    exp_rd.push_back(16'h0000);
    exp_rd.push_back(16'h0001);
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.level == LVL_W'(1)) break;
    end
    chk("t5_first_byte", 32'(bus.level), 32'h1);
    @(negedge clk);
    bus.op_ready = 1'b1;
    @(negedge clk);
    bus.op_ready = 1'b0;
    @(negedge clk);
    bus.op_ready = 1'b1;
    #2;
    chk("t5_hi_before_pop", 32'(bus.op_hi), 32'h1);
    chk("t5_level_before_pop", 32'(bus.level), 32'h1);
    @(negedge clk);
    bus.op_ready = 1'b0;
    #2;
    chk("t5_level_push_pop", 32'(bus.level), 32'h1);
    chk("t5_op_valid", 32'(bus.op_valid), 32'h1);
    chk("t5_op_addr", 32'(bus.op_addr), 32'h1);
    chk("t5_op_hi", 32'(bus.op_hi), 32'h0);
    chk("t5_opcode", 32'(bus.opcode), 32'h3);
    chk("t5_handshakes", 32'(exp_q.size()), 32'h0);

    // 6: reset while waiting on the reader
    do_reset();
    exp_rd.push_back(16'h0000);
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    wait_rd_cnt("t6_first_read", 1);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check_reset_vals("t6_reset");
    exp_rd.delete();
    exp_rd.push_back(16'h0000);
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    repeat (8) @(negedge clk);
    #2;
    chk("t6_restart_addr", 32'(exp_rd.size()), 32'h0);
    chk("t6_rd_cnt", 32'(rd_cnt), 32'd2);
    chk("t6_opcode", 32'(bus.opcode), 32'h1);
    chk("t6_op_addr", 32'(bus.op_addr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
